// File: rtl/stress_pkg.sv
// Shared types and constants for the stress activity controller.
package stress_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } state_e;

   localparam logic [6:0]  RATE_MAX  = 7'd100;
   localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

   // Rates above 100 % behave as 100 %.
   function automatic logic [6:0] clamp_rate(input logic [6:0] rate);
      return (rate > RATE_MAX) ? RATE_MAX : rate;
   endfunction

endpackage

// File: rtl/stress_rate_gen.sv
// One channel of exact-rate toggle generation: a modulo-100 phase accumulator
// whose carry, gated by the channel enable, is registered as the toggle strobe.
module stress_rate_gen
   import stress_pkg::*;
#(
   parameter logic [6:0] PHASE = 7'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       preload,
   input  logic       en,
   input  logic [6:0] rate,
   output logic       pulse_o
);

   logic [6:0] acc_q, acc_d;
   logic       pulse_q, pulse_d;
   logic [7:0] sum;
   logic [7:0] wrapped;

   // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, rate};
      wrapped = sum - {1'b0, RATE_MAX};
      acc_d   = sum[6:0];
      pulse_d = 1'b0;
      if (sum >= {1'b0, RATE_MAX}) begin
         acc_d   = wrapped[6:0];
         pulse_d = en;
      end
      if (preload) begin
         acc_d = PHASE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= 7'd0;
         pulse_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/stress_act_ctrl.sv
// Multi-channel stress activity controller: timed soft-start/soft-stop of channel
// enables, exact-rate toggle strobes and result compaction. STRESS_ACT_MISR_EN
// selects a MISR signature; otherwise the signature is a saturating parity counter.
module stress_act_ctrl
   import stress_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int RAMP_CYCLES = 1024,
   parameter int SIG_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [6:0]        toggle_rate,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [NUM_CH-1:0] ch_din,
   output logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] ch_toggle,
   output logic              busy,
   output logic              ramp_done,
   output logic [SIG_W-1:0]  signature
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  ramp_cnt_q, ramp_cnt_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] ch_en_q, ch_en_d;
   logic [SIG_W-1:0]  sig_q, sig_d;
   logic [NUM_CH-1:0] din_masked;
   logic [6:0]        rate_eff;
   logic              step;
   logic              entry;

   assign step       = (ramp_cnt_q == CNT_LAST);
   assign entry      = (state_q == IDLE) && start;
   assign din_masked = ch_din & ch_en_q;
   assign rate_eff   = clamp_rate(toggle_rate);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         ramp_cnt_q <= '0;
         mask_q     <= '0;
         ch_en_q    <= '0;
         sig_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         ramp_cnt_q <= ramp_cnt_d;
         mask_q     <= mask_d;
         ch_en_q    <= ch_en_d;
         sig_q      <= sig_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (start) state_d = RAMP_UP;
         RAMP_UP: begin
            if (!start)                       state_d = (ptr_q == '0) ? IDLE : RAMP_DOWN;
            else if (step && ptr_q == PTR_LAST) state_d = RUN;
         end
         RUN:       if (!start) state_d = RAMP_DOWN;
         RAMP_DOWN: if (step && ptr_q == '0) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      ramp_cnt_d = ramp_cnt_q;
      mask_d     = mask_q;
      ch_en_d    = ch_en_q;
      sig_d      = sig_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               mask_d     = ch_mask;
               ptr_d      = '0;
               ramp_cnt_d = '0;
               sig_d      = '0;
            end
         end
         RAMP_UP: begin
            if (!start) begin
               // Back off from the last channel that actually got its slot.
               if (ptr_q != '0) ptr_d = ptr_q - PTR_ONE;
               ramp_cnt_d = '0;
            end else if (step) begin
               ch_en_d[ptr_q] = mask_q[ptr_q];
               ramp_cnt_d     = '0;
               if (ptr_q != PTR_LAST) ptr_d = ptr_q + PTR_ONE;
            end else begin
               ramp_cnt_d = ramp_cnt_q + CNT_ONE;
            end
         end
         RUN: begin
`ifdef STRESS_ACT_MISR_EN
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : '0)
                    ^ SIG_W'(din_masked);
`else
            if ((^din_masked) && (sig_q != '1)) sig_d = sig_q + SIG_W'(1);
`endif
            if (!start) begin
               ptr_d      = PTR_LAST;
               ramp_cnt_d = '0;
            end
         end
         RAMP_DOWN: begin
            if (step) begin
               ch_en_d[ptr_q] = 1'b0;
               ramp_cnt_d     = '0;
               if (ptr_q != '0) ptr_d = ptr_q - PTR_ONE;
            end else begin
               ramp_cnt_d = ramp_cnt_q + CNT_ONE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      ramp_done = (state_q == RUN);
   end

   // Phases are spread evenly so channels do not toggle in lockstep.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_rate
      localparam logic [6:0] PH = 7'((i * 100) / NUM_CH);
      stress_rate_gen #(
         .PHASE(PH)
      ) u_rate (
         .clk     (clk),
         .rst_n   (rst_n),
         .preload (entry),
         .en      (ch_en_q[i]),
         .rate    (rate_eff),
         .pulse_o (ch_toggle[i])
      );
   end

   assign ch_en     = ch_en_q;
   assign signature = sig_q;

endmodule
